// File: rtl/palette_pkg.sv
// Shared types for the palette arbiter slice.
//   pal_idx_t          : 8-bit palette index
//   rgb12_t            : 4-bit red/green/blue triple
//   TRANSP_IDX_DEFAULT : index reported as transparent unless overridden
//   arb_state_e        : arbiter FSM states {ARB, LOCK}
//   onehot_to_idx      : one-hot (up to MAX_REQ bits) to binary index
package palette_pkg;

   typedef logic [7:0] pal_idx_t;

   typedef struct packed {
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } rgb12_t;

   localparam pal_idx_t    TRANSP_IDX_DEFAULT = 8'h00;
   localparam int unsigned MAX_REQ            = 8;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // OR-reduction encoder; only valid for a one-hot or all-zero input.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = idx | (oh[i] ? 3'(i) : 3'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker, purely combinational.
//   req        in  N_REQ  eligible requesters
//   last_grant in  ID_W   most recently granted requester
//   grant      out N_REQ  one-hot grant; search starts at last_grant+1 and wraps
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_grant,
   output logic [N_REQ-1:0] grant
);

   logic [ID_W-1:0] cand_s;
   logic            found_s;
   logic            hit_s;

   // Walk the requesters in rotating order; the first one found wins.
   always_comb begin
      grant   = '0;
      cand_s  = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_s        = ID_W'((int'(last_grant) + k) % N_REQ);
         hit_s         = req[cand_s] & ~found_s;
         grant[cand_s] = grant[cand_s] | hit_s;
         found_s       = found_s | hit_s;
      end
   end

endmodule

// File: rtl/palette_arbiter.sv
// Arbitrates N_REQ pixel requesters onto one shared combinational palette
// ROM and registers the looked-up colour in a single-entry output stage.
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_index/req_lock requester side; req_ready one-hot accept
//   pal_index / pal_red,green,blue  palette ROM lookup (same-cycle)
//   rsp_valid/id/red/green/blue/transp, rsp_ready  registered pixel output
module palette_arbiter
   import palette_pkg::*;
#(
   parameter int       N_REQ      = 4,
   parameter pal_idx_t TRANSP_IDX = TRANSP_IDX_DEFAULT
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ-1:0][7:0]        req_index,
   input  logic [N_REQ-1:0]             req_lock,
   output logic [N_REQ-1:0]             req_ready,
   output logic [7:0]                   pal_index,
   input  logic [3:0]                   pal_red,
   input  logic [3:0]                   pal_green,
   input  logic [3:0]                   pal_blue,
   output logic                         rsp_valid,
   output logic [$clog2(N_REQ)-1:0]     rsp_id,
   output logic [3:0]                   rsp_red,
   output logic [3:0]                   rsp_green,
   output logic [3:0]                   rsp_blue,
   output logic                         rsp_transp,
   input  logic                         rsp_ready
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [ID_W-1:0]  last_grant_q, last_grant_d;
   pal_idx_t         last_idx_q, last_idx_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   rgb12_t           rsp_rgb_q, rsp_rgb_d;
   logic             rsp_transp_q, rsp_transp_d;

   logic               out_free_s;
   logic [N_REQ-1:0]   owner_mask_s;
   logic [N_REQ-1:0]   eligible_s;
   logic [N_REQ-1:0]   pick_req_s;
   logic [N_REQ-1:0]   grant_s;
   logic [MAX_REQ-1:0] grant_ext_s;
   logic [2:0]         grant_id3_s;
   logic [ID_W-1:0]    grant_id_s;
   logic               grant_any_s;
   pal_idx_t           grant_idx_s;
   logic               grant_lock_s;
   rgb12_t             pal_rgb_s;

   assign pal_rgb_s = '{red: pal_red, green: pal_green, blue: pal_blue};

   // Eligibility: only the owner while locked; no grant while the output
   // stage is occupied or while reset is held (keeps req_ready low in reset).
   always_comb begin
      out_free_s           = ~rsp_valid_q | rsp_ready;
      owner_mask_s         = '0;
      owner_mask_s[owner_q] = 1'b1;
      if (state_q == LOCK) begin
         eligible_s = req_valid & owner_mask_s;
      end else begin
         eligible_s = req_valid;
      end
      pick_req_s = eligible_s & {N_REQ{out_free_s & reset_n}};
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .req        (pick_req_s),
      .last_grant (last_grant_q),
      .grant      (grant_s)
   );

   // Decode the one-hot grant and steer the winner's index to the ROM.
   always_comb begin
      grant_ext_s              = '0;
      grant_ext_s[N_REQ-1:0]   = grant_s;
      grant_id3_s              = onehot_to_idx(grant_ext_s);
      grant_id_s               = grant_id3_s[ID_W-1:0];
      grant_any_s              = |grant_s;
      grant_idx_s              = req_index[grant_id_s];
      grant_lock_s             = req_lock[grant_id_s];
      if (grant_any_s) begin
         pal_index = grant_idx_s;
      end else begin
         pal_index = last_idx_q;
      end
   end

   assign req_ready = grant_s;

   // Next-state: output stage load/drain and the ARB/LOCK transitions.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      last_idx_d   = last_idx_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_rgb_d    = rsp_rgb_q;
      rsp_transp_d = rsp_transp_q;

      if (grant_any_s) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant_id_s;
         rsp_rgb_d    = pal_rgb_s;
         rsp_transp_d = (grant_idx_s == TRANSP_IDX);
         last_grant_d = grant_id_s;
         last_idx_d   = grant_idx_s;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end else begin
         rsp_valid_d  = rsp_valid_q;
      end

      case (state_q)
         ARB: begin
            if (grant_any_s && grant_lock_s) begin
               state_d = LOCK;
               owner_d = grant_id_s;
            end else begin
               state_d = ARB;
            end
         end
         LOCK: begin
            // In LOCK any grant is necessarily to the owner.
            if (grant_any_s) begin
               state_d = grant_lock_s ? LOCK : ARB;
            end else if (!req_lock[owner_q] && !req_valid[owner_q]) begin
               state_d = ARB;
            end else begin
               state_d = LOCK;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ARB;
         owner_q      <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
         last_idx_q   <= 8'h00;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_rgb_q    <= '0;
         rsp_transp_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         last_idx_q   <= last_idx_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_rgb_q    <= rsp_rgb_d;
         rsp_transp_q <= rsp_transp_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_red    = rsp_rgb_q.red;
   assign rsp_green  = rsp_rgb_q.green;
   assign rsp_blue   = rsp_rgb_q.blue;
   assign rsp_transp = rsp_transp_q;

endmodule

// File: doc/palette_arbiter.md
PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of pixel requesters (tank, bullet, base, background); legal range 2..8.
REQ-002 Parameter TRANSP_IDX, default 8'h00: palette index reported as transparent.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  N_REQ  requester i presents an index.
REQ-006 req_index  in  N_REQ x 8  palette index per requester.
REQ-007 req_lock  in  N_REQ  requester i asks to keep the grant after the current transfer (sprite-row burst).
REQ-008 req_ready  out  N_REQ  one-hot; bit i high means requester i's index is accepted this cycle.
REQ-009 pal_index  out  8  index driven to the shared combinational palette ROM.
REQ-010 pal_red, pal_green, pal_blue  in  4 each  same-cycle palette ROM response to pal_index.
REQ-011 rsp_valid  out  1  output register holds a pixel.
REQ-012 rsp_id  out  clog2(N_REQ)  requester that owns the pixel.
REQ-013 rsp_red, rsp_green, rsp_blue  out  4 each  registered colour.
REQ-014 rsp_transp  out  1  captured index equalled TRANSP_IDX.
REQ-015 rsp_ready  in  1  consumer accepts the pixel.

Function
REQ-016 Transfer out occurs when rsp_valid and rsp_ready are both high; the output stage is free when rsp_valid is low or a transfer out occurs in that cycle.
REQ-017 Grant is issued only when the output stage is free; at most one req_ready bit is high per cycle, and only for a requester whose req_valid is high.
REQ-018 pal_index is combinationally the granted requester's req_index, and is the last granted index when no grant is issued.
REQ-019 On a grant, the next edge loads rsp_red/green/blue from pal_*, rsp_id with the grantee number, and rsp_transp with (req_index == TRANSP_IDX), and sets rsp_valid; latency is exactly 1 cycle.
REQ-020 Without a grant, a transfer out clears rsp_valid; otherwise the output holds all values (no bubble is required under back-to-back grant and drain).
REQ-021 FSM state ARB: round-robin grant; search starts at last_grant+1 modulo N_REQ and wraps.
REQ-022 ARB -> LOCK on a grant to requester i with req_lock[i] high; the locked owner is i.
REQ-023 LOCK: only the owner is eligible; other requesters wait even when the owner's req_valid is low.
REQ-024 LOCK -> ARB on a grant to the owner with req_lock low, or in any cycle where the owner has req_lock low and req_valid low.
REQ-025 last_grant updates on every grant; in LOCK the round-robin order resumes after the owner.
REQ-026 A requester with req_valid high and req_ready low SHALL see its request unconsumed; the arbiter never drops or duplicates an index.
REQ-027 With N_REQ requesters continuously valid and unlocked, each is granted exactly once in every N_REQ consecutive grants.

Reset
REQ-028 While reset_n is low: rsp_valid=0, rsp_id=0, rsp_red/green/blue=0, rsp_transp=0, req_ready=0, FSM=ARB, last_grant=N_REQ-1 (requester 0 first), pal_index=0.
REQ-029 Reset asserted mid-burst or with a pending pixel discards the pixel and the lock; operation resumes on the first edge after deassertion.

Structure
REQ-030 Shared package palette_pkg holds the rgb12_t struct (3x4-bit), the palette index type (8-bit), TRANSP_IDX default, and the arbiter state enum {ARB, LOCK}.
REQ-031 The round-robin priority picker is one sub-module, rr_pick (request vector plus last_grant in, one-hot grant out, purely combinational); the palette ROM stays outside this block.

Verification
REQ-032 Single requester 0, index 8'h07, rsp_ready=1 -> req_ready[0] in cycle 0; next cycle rsp_valid=1, rsp_id=0, RGB=F,F,F, rsp_transp=0.
REQ-033 Index 8'h00 from requester 2 -> RGB=0,0,0, rsp_transp=1, rsp_id=2; index 8'h01 -> RGB=6,7,2, rsp_transp=0.
REQ-034 All 4 valid, no locks, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one pixel every cycle.
REQ-035 rsp_ready=0 for 5 cycles with all valid -> one pixel held stable, req_ready=0 throughout; on release the next grantee follows without loss.
REQ-036 Requester 1 holds req_lock for 4 indices while 0,2,3 are valid -> 4 consecutive grants to 1, then 2,3,0.
REQ-037 reset_n pulsed low during LOCK with rsp_valid=1 -> all outputs 0 immediately; first grant after deassertion goes to requester 0.
